// File: rtl/ecc_secded_decode_pipe.sv
// ecc_secded_decode_pipe: 2-stage pipelined Hamming SEC decoder with
// optional DED (define ECC_DED_EN), valid/ready flow and error counters.
// Ports: clk, rst (sync, active high); in_valid/in_ready/in_enc (encoded
// word in); out_valid/out_ready/out_data/out_syndrome/out_sec/out_uncorr
// (decoded word out); clr_cnt, sec_cnt, uncorr_cnt (saturating counters).
module ecc_secded_decode_pipe #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16,
  localparam int PAR_W =
    (DATA_W + 4  <= 8)    ? 3 :
    (DATA_W + 5  <= 16)   ? 4 :
    (DATA_W + 6  <= 32)   ? 5 :
    (DATA_W + 7  <= 64)   ? 6 :
    (DATA_W + 8  <= 128)  ? 7 :
    (DATA_W + 9  <= 256)  ? 8 :
    (DATA_W + 10 <= 512)  ? 9 :
    (DATA_W + 11 <= 1024) ? 10 : 11,
  localparam int HW_W  = DATA_W + PAR_W,
`ifdef ECC_DED_EN
  localparam int ENC_W = HW_W + 1
`else
  localparam int ENC_W = HW_W
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ENC_W-1:0]  in_enc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [PAR_W-1:0]  out_syndrome,
  output logic              out_sec,
  output logic              out_uncorr,
  input  logic              clr_cnt,
  output logic [CNT_W-1:0]  sec_cnt,
  output logic [CNT_W-1:0]  uncorr_cnt
);

  logic              s1_valid_q;
  logic [HW_W-1:0]   s1_raw_q;
  logic [PAR_W-1:0]  s1_syn_q;
  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;
  logic [PAR_W-1:0]  out_syn_q;
  logic              out_sec_q;
  logic              out_unc_q;
  logic [CNT_W-1:0]  sec_cnt_q, sec_cnt_d;
  logic [CNT_W-1:0]  unc_cnt_q, unc_cnt_d;

  logic              s1_adv, in_fire, out_fire;
  logic [PAR_W-1:0]  syn_d;
  logic              syn_nz, in_rng, do_fix;
  logic              sec_d, unc_d;
  logic [HW_W-1:0]   fix_d;
  logic [DATA_W-1:0] data_d;

  assign s1_adv   = !out_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s1_adv;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid_q && out_ready;

  // Syndrome bit k covers every position whose index has bit k set.
  always_comb begin
    syn_d = '0;
    for (int p = 1; p <= HW_W; p++) begin
      for (int k = 0; k < PAR_W; k++) begin
        if (((p >> k) & 1) == 1)
          syn_d[k] = syn_d[k] ^ in_enc[p-1];
      end
    end
  end

  assign syn_nz = |s1_syn_q;
  assign in_rng = syn_nz && (int'(s1_syn_q) <= HW_W);

`ifdef ECC_DED_EN
  logic s1_par_q;
  logic par_d;

  // Overall parity includes the extra parity bit itself.
  assign par_d  = ^in_enc;
  // Odd overall parity means an odd error count: one error is fixable,
  // and syn==0 points at the overall parity bit alone.
  assign do_fix = s1_par_q && in_rng;
  assign sec_d  = s1_par_q && (!syn_nz || in_rng);
  assign unc_d  = syn_nz && !(s1_par_q && in_rng);
`else
  assign do_fix = in_rng;
  assign sec_d  = in_rng;
  assign unc_d  = syn_nz && !in_rng;
`endif

  always_comb begin
    fix_d = s1_raw_q;
    for (int p = 1; p <= HW_W; p++) begin
      if (do_fix && int'(s1_syn_q) == p)
        fix_d[p-1] = ~s1_raw_q[p-1];
    end
  end

  // Data occupies the non-power-of-two positions in ascending order.
  always_comb begin
    int j;
    data_d = '0;
    j = 0;
    for (int p = 1; p <= HW_W; p++) begin
      if ((p & (p - 1)) != 0) begin
        data_d[j] = fix_d[p-1];
        j++;
      end
    end
  end

  always_comb begin
    sec_cnt_d = sec_cnt_q;
    unc_cnt_d = unc_cnt_q;
    if (clr_cnt) begin
      sec_cnt_d = '0;
      unc_cnt_d = '0;
    end else if (out_fire) begin
      if (out_sec_q && sec_cnt_q != '1)
        sec_cnt_d = sec_cnt_q + CNT_W'(1);
      if (out_unc_q && unc_cnt_q != '1)
        unc_cnt_d = unc_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_raw_q    <= '0;
      s1_syn_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_syn_q   <= '0;
      out_sec_q   <= 1'b0;
      out_unc_q   <= 1'b0;
      sec_cnt_q   <= '0;
      unc_cnt_q   <= '0;
    end else begin
      if (in_ready)
        s1_valid_q <= in_valid;
      if (in_fire) begin
        s1_raw_q <= in_enc[HW_W-1:0];
        s1_syn_q <= syn_d;
      end
      if (s1_adv) begin
        out_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          out_data_q <= data_d;
          out_syn_q  <= s1_syn_q;
          out_sec_q  <= sec_d;
          out_unc_q  <= unc_d;
        end
      end
      sec_cnt_q <= sec_cnt_d;
      unc_cnt_q <= unc_cnt_d;
    end
  end

`ifdef ECC_DED_EN
  always_ff @(posedge clk) begin
    if (rst)
      s1_par_q <= 1'b0;
    else if (in_fire)
      s1_par_q <= par_d;
  end
`endif

  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign out_syndrome = out_syn_q;
  assign out_sec      = out_sec_q;
  assign out_uncorr   = out_unc_q;
  assign sec_cnt      = sec_cnt_q;
  assign uncorr_cnt   = unc_cnt_q;

endmodule

// File: tb/tb_ecc_secded_decode_pipe.sv
// Bench for ecc_secded_decode_pipe: fixed vectors, backpressure, counter
// saturation/clear, mid-stream reset and random traffic vs a model.
module tb_ecc_secded_decode_pipe;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 2;
  localparam int PAR_W  = 6;
  localparam int HW_W   = 38;
`ifdef ECC_DED_EN
  localparam int ENC_W  = 39;
`else
  localparam int ENC_W  = 38;
`endif
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [ENC_W-1:0]  in_enc = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [DATA_W-1:0] out_data;
  logic [PAR_W-1:0]  out_syndrome;
  logic              out_sec;
  logic              out_uncorr;
  logic              clr_cnt = 1'b0;
  logic [CNT_W-1:0]  sec_cnt;
  logic [CNT_W-1:0]  uncorr_cnt;

  ecc_secded_decode_pipe #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_enc(in_enc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_syndrome(out_syndrome),
    .out_sec(out_sec), .out_uncorr(out_uncorr),
    .clr_cnt(clr_cnt), .sec_cnt(sec_cnt), .uncorr_cnt(uncorr_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [DATA_W-1:0] data;
    int                syn;
    bit                sec;
    bit                unc;
  } rec_t;

  function automatic logic [ENC_W-1:0] encode(input logic [DATA_W-1:0] d);
    logic [ENC_W-1:0] w;
    int j;
    int s;
    w = '0;
    j = 0;
    s = 0;
    for (int p = 1; p <= HW_W; p++)
      if ((p & (p - 1)) != 0) begin
        w[p-1] = d[j];
        j++;
      end
    // Syndrome is the XOR of the indices of all set bits; set parity
    // bits so that XOR becomes zero.
    for (int p = 1; p <= HW_W; p++)
      if (w[p-1]) s = s ^ p;
    for (int k = 0; k < PAR_W; k++)
      if (s[k]) w[(1 << k) - 1] = 1'b1;
`ifdef ECC_DED_EN
    w[ENC_W-1] = ^w[ENC_W-2:0];
`endif
    return w;
  endfunction

  function automatic rec_t ref_dec(input logic [ENC_W-1:0] w);
    rec_t r;
    logic [ENC_W-1:0] f;
    int syn;
    int j;
    bit fix;
    syn = 0;
    for (int p = 1; p <= HW_W; p++)
      if (w[p-1]) syn = syn ^ p;
`ifdef ECC_DED_EN
    begin
      bit par;
      par = ^w;
      if (syn == 0) begin
        r.sec = par; r.unc = 0; fix = 0;
      end else if (par) begin
        fix = (syn <= HW_W); r.sec = fix; r.unc = !fix;
      end else begin
        r.sec = 0; r.unc = 1; fix = 0;
      end
    end
`else
    fix   = (syn != 0) && (syn <= HW_W);
    r.sec = fix;
    r.unc = (syn > HW_W);
`endif
    f = w;
    if (fix) f[syn-1] = ~f[syn-1];
    r.data = '0;
    j = 0;
    for (int p = 1; p <= HW_W; p++)
      if ((p & (p - 1)) != 0) begin
        r.data[j] = f[p-1];
        j++;
      end
    r.syn = syn;
    return r;
  endfunction

  // Scoreboard: expected records queued on input handshake.
  rec_t q[$];
  rec_t mon_e;
  int   sec_m = 0;
  int   unc_m = 0;
  int   n_out = 0;

  always @(negedge clk) begin
    bit inc_s, inc_u;
    inc_s = 0;
    inc_u = 0;
    if (rst) begin
      q.delete();
      sec_m = 0;
      unc_m = 0;
    end else begin
      chk("sec_cnt", sec_cnt, sec_m);
      chk("uncorr_cnt", uncorr_cnt, unc_m);
      if (out_valid) begin
        chk("out_expected", q.size() != 0, 1);
        if (q.size() != 0) begin
          mon_e = q[0];
          chk("out_data", out_data, mon_e.data);
          chk("out_syndrome", out_syndrome, mon_e.syn);
          chk("out_sec", out_sec, mon_e.sec);
          chk("out_uncorr", out_uncorr, mon_e.unc);
          if (out_ready) begin
            void'(q.pop_front());
            inc_s = mon_e.sec;
            inc_u = mon_e.unc;
            n_out++;
          end
        end
      end
      if (clr_cnt) begin
        sec_m = 0;
        unc_m = 0;
      end else begin
        if (inc_s && sec_m < CMAX) sec_m++;
        if (inc_u && unc_m < CMAX) unc_m++;
      end
      if (in_valid && in_ready) q.push_back(ref_dec(in_enc));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    clr_cnt = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic drain(input string name);
    int left;
    in_valid = 1'b0;
    out_ready = 1'b1;
    left = 20;
    while (left > 0 && (q.size() != 0 || out_valid)) begin
      step();
      left--;
    end
    @(negedge clk);
    chk(name, q.size(), 0);
    step();
  endtask

  typedef struct {
    int                fa;
    int                fb;
    logic [DATA_W-1:0] data;
    int                syn;
    bit                sec;
    bit                unc;
  } vec_t;

  vec_t vt[7];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation timed out");
    $fatal(1, "timeout");
  end

  initial begin
    logic [ENC_W-1:0] w;
    logic [ENC_W-1:0] m;
    int lat;

    vt[0] = '{-1, -1, 32'hDEADBEEF, 0,  1'b0, 1'b0};
    vt[1] = '{ 2, -1, 32'hDEADBEEF, 3,  1'b1, 1'b0};
    vt[2] = '{ 3, -1, 32'hDEADBEEF, 4,  1'b1, 1'b0};
`ifdef ECC_DED_EN
    vt[3] = '{ 2,  4, 32'hDEADBEEC, 6,  1'b0, 1'b1};
    vt[5] = '{38, -1, 32'hDEADBEEF, 0,  1'b1, 1'b0};
`else
    vt[3] = '{ 2,  4, 32'hDEADBEE8, 6,  1'b1, 1'b0};
    vt[5] = '{37, -1, 32'hDEADBEEF, 38, 1'b1, 1'b0};
`endif
    vt[4] = '{ 6, 31, 32'hDEADBEE7, 39, 1'b0, 1'b1};
    vt[6] = '{ 0, -1, 32'hDEADBEEF, 1,  1'b1, 1'b0};

    apply_reset();
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_syndrome", out_syndrome, 0);
    chk("rst_out_sec", out_sec, 0);
    chk("rst_out_uncorr", out_uncorr, 0);
    chk("rst_sec_cnt", sec_cnt, 0);
    chk("rst_uncorr_cnt", uncorr_cnt, 0);
    chk("rst_in_ready", in_ready, 1);
    step();

    // Fixed vectors, one at a time.
    for (int i = 0; i < 7; i++) begin
      m = '0;
      if (vt[i].fa >= 0) m[vt[i].fa] = 1'b1;
      if (vt[i].fb >= 0) m[vt[i].fb] = 1'b1;
      w = encode(32'hDEADBEEF) ^ m;
      in_valid = 1'b1;
      in_enc = w;
      step();
      in_valid = 1'b0;
      lat = -1;
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        if (out_valid) begin
          lat = c;
          break;
        end
      end
      chk($sformatf("vec%0d_latency", i), lat, 1);
      chk($sformatf("vec%0d_data", i), out_data, vt[i].data);
      chk($sformatf("vec%0d_syn", i), out_syndrome, vt[i].syn);
      chk($sformatf("vec%0d_sec", i), out_sec, vt[i].sec);
      chk($sformatf("vec%0d_uncorr", i), out_uncorr, vt[i].unc);
      step();
    end
    @(negedge clk);
    chk("vec_sec_cnt_sat", sec_cnt, 3);
`ifdef ECC_DED_EN
    chk("vec_uncorr_cnt", uncorr_cnt, 2);
`else
    chk("vec_uncorr_cnt", uncorr_cnt, 1);
`endif
    step();

    // Backpressure: 4 words, out_ready low for 3 cycles.
    begin
      logic [DATA_W-1:0] bw[4];
      int acc, first, n0;
      acc = 0;
      first = -1;
      n0 = n_out;
      for (int i = 0; i < 4; i++) bw[i] = $urandom;
      for (int c = 0; c < 30; c++) begin
        in_valid = (acc < 4);
        in_enc = encode(bw[(acc < 4) ? acc : 0]);
        if (first < 0 && out_valid) first = c;
        out_ready = !(first >= 0 && c < first + 3);
        @(negedge clk);
        if (first >= 0 && c < first + 3) begin
          chk("bp_in_ready_low", in_ready, 0);
          chk("bp_hold_valid", out_valid, 1);
          chk("bp_hold_data", out_data, bw[0]);
        end
        if (in_valid && in_ready) acc++;
        step();
      end
      drain("bp_drain");
      chk("bp_out_count", n_out - n0, 4);
      chk("bp_stall_seen", first >= 0, 1);
    end

    // Counter saturation then clear coincident with a sec handshake.
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      m = '0;
      m[$urandom_range(0, ENC_W - 1)] = 1'b1;
      in_valid = 1'b1;
      in_enc = encode($urandom) ^ m;
      step();
    end
    drain("sat_drain");
    @(negedge clk);
    chk("sat_sec_cnt", sec_cnt, 3);
    step();
    m = '0;
    m[5] = 1'b1;
    in_valid = 1'b1;
    in_enc = encode($urandom) ^ m;
    step();
    in_valid = 1'b0;
    lat = -1;
    for (int c = 0; c < 10; c++) begin
      if (out_valid) begin
        lat = c;
        break;
      end
      step();
    end
    chk("clr_out_seen", lat >= 0, 1);
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
    @(negedge clk);
    chk("clr_sec_cnt", sec_cnt, 0);
    step();

    // Reset mid-stream: in-flight words must vanish.
    m = '0;
    m[9] = 1'b1;
    in_valid = 1'b1;
    in_enc = encode($urandom) ^ m;
    step();
    in_enc = encode($urandom) ^ m;
    step();
    in_valid = 1'b0;
    out_ready = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    begin
      int seen;
      seen = 0;
      for (int c = 0; c < 5; c++) begin
        @(negedge clk);
        if (out_valid) seen++;
        step();
      end
      chk("rst_mid_no_out", seen, 0);
      @(negedge clk);
      chk("rst_mid_sec_cnt", sec_cnt, 0);
      step();
    end

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      m = '0;
      for (int k = $urandom_range(0, 2); k > 0; k--)
        m[$urandom_range(0, ENC_W - 1)] = 1'b1;
      in_valid = ($urandom_range(0, 9) < 7);
      in_enc = encode($urandom) ^ m;
      out_ready = ($urandom_range(0, 9) < 7);
      clr_cnt = ($urandom_range(0, 49) == 0);
      step();
    end
    clr_cnt = 1'b0;
    drain("rand_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
